two_digit_display_driver: RTL and testbench
===========================================

# two_digit_display_driver

Downstream display stage for the frequency counter: accepts a binary count (0–127), converts it to two BCD digits with a sequential shift-add-3 engine, and time-multiplexes the digits onto one 7-segment bus plus a single digit-select line. It produces the `segments`/`digit` pair that the wrapper routes to the IO pads. The count source loads it with a one-cycle strobe whenever a new measurement is ready.

## Interface
- `REFRESH_DIV`, default 100: clock cycles each digit is shown before `digit` toggles; legal range ≥2.
- `clk` in 1: system clock (`wb_clk_i` at the wrapper).
- `reset` in 1: asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `value` in 7: binary count to display.
- `load` in 1: one-cycle strobe; `value` is sampled when `load`=1 and `busy`=0.
- `busy` out 1: conversion in progress; a `load` is ignored while this is high.
- `segments` out 7: {g,f,e,d,c,b,a}, active-high, registered.
- `digit` out 1: 0 = units digit driven, 1 = tens digit driven; registered.

## Operation
- Reset values: `busy`=0, `digit`=0, `segments`=7'h3F, stored tens=0, stored units=0, refresh counter=0, FSM=IDLE.
- FSM states:
  - IDLE → CONVERT on an accepted `load`.
  - CONVERT runs exactly 7 shift steps, then returns to IDLE.
- Saturation: a captured `value` >99 is replaced by 99 before conversion.
- Conversion uses an 8-bit BCD scratch register (tens[3:0], units[3:0]) plus a 7-bit shift register.
  - Each CONVERT cycle: add 3 to any nibble ≥5, then shift left one bit.
  - A 3-bit step counter ends CONVERT after step 7.
- Commit: on the edge that completes step 7, the stored tens/units registers are written atomically. A partial result is never displayed.
- A `load` while `busy`=1 is dropped, not queued.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On the wrap edge `digit` inverts.
  - It runs independently of conversion.
- `segments` register:
  - Loads every cycle the decode of the digit selected by the post-edge `digit` value, using the stored tens/units as they were before that edge.
  - `segments` and `digit` are therefore always coherent.
- Decode for 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F. Stored values are always ≤9, so no other codes are required.
- Reset asserted mid-conversion: CONVERT is aborted, the scratch contents are discarded, and all registers return to their reset values immediately (asynchronous).

## Timing
- `load` sampled at edge E0 → `busy`=1 after E0 through E7; `busy`=0 after E7. That is 7 cycles busy, so the earliest next accepted `load` is sampled at E8.
- Stored digits update at E7. `segments` reflects them after E8 (1-cycle display latency), for whichever digit is selected.
- `digit` period = 2×REFRESH_DIV cycles. The first toggle occurs at the REFRESH_DIV-th edge after reset release.
- A `load` and a refresh wrap on the same edge are independent; both take effect.

## Configuration
- `DISPLAY_LEADING_ZERO_BLANK_EN`
  - Defined: when the stored tens = 0 and `digit`=1, `segments` = 7'h00 (tens digit blank). The units digit is never blanked; 0 displays as a single "0".
  - Undefined: the tens digit always shows its decode, so a stored 0 gives 7'h3F.
  - The reset value of `segments` (digit=0 → 7'h3F) is the same in both builds.

## Test plan
- Reset → `segments`=7'h3F, `digit`=0, `busy`=0. With REFRESH_DIV=4, `digit` toggles every 4 cycles and `segments` stays 7'h3F on the units digit. On the tens digit `segments` is 7'h3F (undefined) or 7'h00 (defined).
- `value`=42, `load` pulse → `busy` high exactly 7 cycles. Afterwards `segments`=7'h66 while `digit`=1 and 7'h5B while `digit`=0.
- `value`=127, `load` → saturates; both digits show 7'h6F.
- `load` 42, then `load` 13 three cycles later (while `busy`) → the 13 is ignored and the display ends at 42. A `load` of 13 at E8 is accepted and the display shows 1/3 (06/4F).
- `value`=7 → units 7'h07. Tens shows 7'h00 with `DISPLAY_LEADING_ZERO_BLANK_EN`, 7'h3F without it.
- `load` 99, assert `reset` at step 4 → `busy`=0 and `segments`=7'h3F immediately, the stored digits are 0, and no commit occurs after `reset` is released.

Source files
------------

// File: rtl/two_digit_display_driver.sv
// Binary (0-127, saturated to 99) to two-digit BCD via sequential shift-add-3,
// multiplexed onto one 7-segment bus. Optional macro: DISPLAY_LEADING_ZERO_BLANK_EN.
module two_digit_display_driver #(
  parameter int REFRESH_DIV = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] value,
  input  logic       load,
  output logic       busy,
  output logic [6:0] segments,
  output logic       digit,
  output logic [3:0] dbg_state
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  // Handshake: value is captured on any edge where load=1 and busy=0;
  // loads seen while busy=1 are dropped, never queued.
  typedef enum logic [0:0] {IDLE = 1'b0, CONVERT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [2:0]       step_q;
  logic [6:0]       shift_q;
  logic [7:0]       bcd_q;
  logic [3:0]       tens_q, units_q;
  logic [CNT_W-1:0] refresh_q;
  logic             accept, last_step;
  logic [3:0]       tens_adj, units_adj;
  logic [14:0]      dd_shift;
  logic             wrap, digit_d;
  logic [3:0]       sel_digit;
  logic [6:0]       seg_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    last_step = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          accept  = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        busy = 1'b1;
        if (step_q == 3'd6) begin
          last_step = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbg_state = {state_q, step_q};

  // One double-dabble step: correct nibbles >=5, then shift the whole pair left.
  always_comb begin
    units_adj = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    tens_adj  = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    dd_shift  = {tens_adj, units_adj, shift_q} << 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      shift_q <= 7'd0;
      bcd_q   <= 8'd0;
      tens_q  <= 4'd0;
      units_q <= 4'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        shift_q <= (value > 7'd99) ? 7'd99 : value;
        bcd_q   <= 8'd0;
        step_q  <= 3'd0;
      end else if (state_q == CONVERT) begin
        bcd_q   <= dd_shift[14:7];
        shift_q <= dd_shift[6:0];
        step_q  <= step_q + 3'd1;
        if (last_step) begin
          tens_q  <= dd_shift[14:11];
          units_q <= dd_shift[10:7];
        end
      end
    end
  end

  // Segments are decoded for the digit that will be selected after this edge,
  // so the segments/digit pair is always coherent.
  always_comb begin
    wrap      = (refresh_q == CNT_MAX);
    digit_d   = digit ^ wrap;
    sel_digit = digit_d ? tens_q : units_q;
    seg_d     = seg_decode(sel_digit);
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    if (digit_d && (tens_q == 4'd0)) seg_d = 7'h00;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_q <= '0;
      digit     <= 1'b0;
      segments  <= 7'h3F;
    end else begin
      refresh_q <= wrap ? '0 : refresh_q + 1'b1;
      digit     <= digit_d;
      segments  <= seg_d;
    end
  end

endmodule

// File: tb/tb_two_digit_display_driver.sv
// Bench for two_digit_display_driver: arithmetic reference model checked every
// cycle, plus literal expectations from hand-worked display cases.
module tb_two_digit_display_driver;

  localparam int DIV = 4;
  localparam logic [6:0] SEG_TAB [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] TENS_ZERO = 7'h00;
`else
  localparam logic [6:0] TENS_ZERO = 7'h3F;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [6:0] value = 7'd0;
  logic       busy;
  logic [6:0] segments;
  logic       digit;
  logic [3:0] dbg_state;

  int n_checks = 0;
  int n_pass = 0;

  two_digit_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .busy(busy),
    .segments(segments), .digit(digit), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // reference model: loads waiting to commit, busy countdown, digits as integers
  logic [6:0] exp_q[$];
  int         m_edges = 0;
  int         m_busy_left = 0;
  int         m_tens = 0;
  int         m_units = 0;
  int         m_old_t, m_old_u, m_d;
  logic [6:0] m_v;
  logic [6:0] m_seg = 7'h3F;
  logic       m_digit = 1'b0;
  logic       m_busy = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_edges = 0; m_busy_left = 0; exp_q.delete();
      m_tens = 0; m_units = 0; m_seg = 7'h3F; m_digit = 1'b0; m_busy = 1'b0;
    end else begin
      m_old_t = m_tens;
      m_old_u = m_units;
      if (m_busy_left == 0) begin
        if (load) begin
          exp_q.push_back((value > 7'd99) ? 7'd99 : value);
          m_busy_left = 7;
        end
      end else begin
        m_busy_left--;
        if (m_busy_left == 0) begin
          m_v = exp_q.pop_front();
          m_tens = int'(m_v) / 10;
          m_units = int'(m_v) % 10;
        end
      end
      m_edges++;
      m_digit = ((m_edges / DIV) % 2) == 1;
      m_busy = (m_busy_left > 0);
      m_d = m_digit ? m_old_t : m_old_u;
      m_seg = SEG_TAB[m_d];
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
      if (m_digit && m_old_t == 0) m_seg = 7'h00;
`endif
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    check("busy", busy, m_busy);
    check("digit", digit, m_digit);
    check("segments", segments, m_seg);
  end

  // driver tasks
  task automatic do_load(input logic [6:0] v);
    value = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_digit(input logic v);
    for (int i = 0; i < 3 * DIV; i++) begin
      if (digit == v) return;
      @(negedge clk);
    end
    check("wait_digit_timeout", digit, v);
  endtask

  task automatic show_check(input string name, input logic [6:0] tens_seg,
                            input logic [6:0] units_seg);
    wait_digit(1'b1);
    check({name, "_tens"}, segments, tens_seg);
    wait_digit(1'b0);
    check({name, "_units"}, segments, units_seg);
  endtask

  int busy_cnt;

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_seg", segments, 7'h3F);
    check("rst_digit", digit, 0);
    check("rst_busy", busy, 0);

    repeat (DIV) @(negedge clk);
    check("first_toggle_digit", digit, 1);
    check("idle_tens_seg", segments, TENS_ZERO);
    repeat (DIV) @(negedge clk);
    check("second_toggle_digit", digit, 0);
    check("idle_units_seg", segments, 7'h3F);

    // 42: busy exactly 7 cycles, then 4/2
    do_load(7'd42);
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    check("busy_len_42", busy_cnt, 7);
    show_check("val42", 7'h66, 7'h5B);

    // 127 saturates to 99
    do_load(7'd127);
    repeat (10) @(negedge clk);
    show_check("val127", 7'h6F, 7'h6F);

    // load while busy is dropped; load at E8 is accepted
    do_load(7'd42);
    repeat (2) @(negedge clk);
    do_load(7'd13);
    repeat (4) @(negedge clk);
    do_load(7'd13);
    check("e8_accept_busy", busy, 1);
    check("e8_shows_42", segments, digit ? 7'h66 : 7'h5B);
    repeat (10) @(negedge clk);
    show_check("val13", 7'h06, 7'h4F);

    // 7: leading tens digit
    do_load(7'd7);
    repeat (10) @(negedge clk);
    show_check("val7", TENS_ZERO, 7'h07);

    // randomized loads, including many during busy
    for (int i = 0; i < 300; i++) begin
      value = 7'($urandom_range(0, 127));
      load = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    load = 1'b0;
    repeat (10) @(negedge clk);

    // reset mid-conversion: no commit afterwards
    do_load(7'd99);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_seg", segments, 7'h3F);
    check("midrst_digit", digit, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    show_check("post_rst", TENS_ZERO, 7'h3F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
